// File: rtl/edge_event_pkg.sv
// Shared types for the edge event controller: arbiter FSM state and the
// event record offered on the output port.
package edge_event_pkg;

    // Widest channel index the event record can carry.
    localparam int EvtChMaxW = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    typedef struct packed {
        logic [EvtChMaxW-1:0] ch;
        logic                 rise;
    } evt_t;

endpackage

// File: rtl/edge_event_chan.sv
// One input channel: two-flop synchroniser, debounce counter, stable value
// and single-cycle rise/fall pulses coincident with the stable value update.
module edge_event_chan #(
    parameter int DebounceCycles = 4
) (
    input  logic clk,
    input  logic rst_ni,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    localparam int              CntW    = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

    logic            s1;
    logic            s2;
    logic            st;
    logic [CntW-1:0] cnt;
    logic            upd;

    // The stable value flips on the cycle the counter has already seen
    // DebounceCycles-1 consecutive differing samples and sees one more.
    assign upd    = (s2 != st) && (cnt == CntLast);
    assign rise_o = upd & s2;
    assign fall_o = upd & ~s2;

    // Two-flop synchroniser for the asynchronous input.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= sig_i;
            s2 <= s1;
        end
    end

    // Debounce: count consecutive disagreeing samples, restart on agreement.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            st  <= 1'b0;
            cnt <= '0;
        end else if (s2 == st) begin
            cnt <= '0;
        end else if (upd) begin
            st  <= s2;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/edge_event_ctrl.sv
// Multi-channel edge event controller: per-channel debounced edge detection,
// pending/overflow latching and a round-robin arbiter feeding a single
// valid/ready event port.
module edge_event_ctrl
    import edge_event_pkg::*;
#(
    parameter  int NumCh          = 4,
    parameter  int DebounceCycles = 4,
    localparam int ChW            = $clog2(NumCh)
) (
    input  logic               clk,
    input  logic               rst_ni,
    input  logic [NumCh-1:0]   sig_i,
    input  logic [NumCh-1:0]   rise_en_i,
    input  logic [NumCh-1:0]   fall_en_i,
    output logic               evt_valid_o,
    input  logic               evt_ready_i,
    output logic [ChW-1:0]     evt_ch_o,
    output logic               evt_rise_o,
    output logic [2*NumCh-1:0] pending_o,
    output logic [NumCh-1:0]   ovf_o,
    input  logic [NumCh-1:0]   ovf_clr_i
);

    logic [NumCh-1:0] rise_evt;
    logic [NumCh-1:0] fall_evt;
    logic [NumCh-1:0] rise_set;
    logic [NumCh-1:0] fall_set;
    logic [NumCh-1:0] rise_clr;
    logic [NumCh-1:0] fall_clr;
    logic [NumCh-1:0] rise_pend_q;
    logic [NumCh-1:0] fall_pend_q;
    logic [NumCh-1:0] ovf_set;
    logic [NumCh-1:0] ovf_q;

    state_e           state_q;
    evt_t             evt_q;
    logic             valid_q;
    logic [ChW-1:0]   rr_q;

    logic             found;
    logic [ChW-1:0]   sel_ch;
    logic             sel_rise;
    logic [ChW:0]     idx_w;
    logic             grab;
    logic [ChW-1:0]   rr_next;

    for (genvar i = 0; i < NumCh; i++) begin : g_ch
        edge_event_chan #(
            .DebounceCycles(DebounceCycles)
        ) u_chan (
            .clk    (clk),
            .rst_ni (rst_ni),
            .sig_i  (sig_i[i]),
            .rise_o (rise_evt[i]),
            .fall_o (fall_evt[i])
        );
    end

    // Disabled edges are dropped here and never reach the pending bits.
    assign rise_set = rise_evt & rise_en_i;
    assign fall_set = fall_evt & fall_en_i;

    // Round-robin search from rr_q with wrap-around; rise beats fall in a channel.
    always_comb begin
        found    = 1'b0;
        sel_ch   = '0;
        sel_rise = 1'b0;
        idx_w    = '0;
        for (int i = 0; i < NumCh; i++) begin
            idx_w = {1'b0, rr_q} + (ChW+1)'(i);
            if (idx_w >= (ChW+1)'(NumCh)) begin
                idx_w = idx_w - (ChW+1)'(NumCh);
            end
            if (!found && (rise_pend_q[idx_w[ChW-1:0]] || fall_pend_q[idx_w[ChW-1:0]])) begin
                found    = 1'b1;
                sel_ch   = idx_w[ChW-1:0];
                sel_rise = rise_pend_q[idx_w[ChW-1:0]];
            end
        end
    end

    assign grab    = (state_q == IDLE) && found;
    assign rr_next = (sel_ch == ChW'(NumCh - 1)) ? '0 : sel_ch + 1'b1;

    // One-hot clear of the pending bit taken by the arbiter this cycle.
    always_comb begin
        rise_clr = '0;
        fall_clr = '0;
        if (grab) begin
            if (sel_rise) begin
                rise_clr[sel_ch] = 1'b1;
            end else begin
                fall_clr[sel_ch] = 1'b1;
            end
        end
    end

    // An edge landing on a still-pending bit that is not being taken loses an event.
    assign ovf_set = (rise_set & rise_pend_q & ~rise_clr) |
                     (fall_set & fall_pend_q & ~fall_clr);

    // Pending and overflow registers; a set always beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            rise_pend_q <= '0;
            fall_pend_q <= '0;
            ovf_q       <= '0;
        end else begin
            rise_pend_q <= (rise_pend_q & ~rise_clr) | rise_set;
            fall_pend_q <= (fall_pend_q & ~fall_clr) | fall_set;
            ovf_q       <= (ovf_q & ~ovf_clr_i) | ovf_set;
        end
    end

    // Arbiter FSM: grab in IDLE, hold the offered event stable in OFFER.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            evt_q   <= '0;
            valid_q <= 1'b0;
            rr_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        evt_q.ch   <= EvtChMaxW'(sel_ch);
                        evt_q.rise <= sel_rise;
                        rr_q       <= rr_next;
                        valid_q    <= 1'b1;
                        state_q    <= OFFER;
                    end
                end
                OFFER: begin
                    if (evt_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    if (ChW < EvtChMaxW) begin : g_ch_hi
        logic unused_ch_hi;
        assign unused_ch_hi = ^evt_q.ch[EvtChMaxW-1:ChW];
    end

    assign evt_valid_o = valid_q;
    assign evt_ch_o    = evt_q.ch[ChW-1:0];
    assign evt_rise_o  = evt_q.rise;
    assign pending_o   = {fall_pend_q, rise_pend_q};
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_edge_event_ctrl.sv
// Bench for edge_event_ctrl: expected events are queued as stimulus is
// driven and compared in order at each output handshake.
module tb_edge_event_ctrl;

    typedef struct packed {
        logic [1:0] ch;
        logic       rise;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic [3:0] sig_i;
    logic [3:0] rise_en_i;
    logic [3:0] fall_en_i;
    logic       evt_valid_o;
    logic       evt_ready_i;
    logic [1:0] evt_ch_o;
    logic       evt_rise_o;
    logic [7:0] pending_o;
    logic [3:0] ovf_o;
    logic [3:0] ovf_clr_i;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    edge_event_ctrl #(
        .NumCh          (4),
        .DebounceCycles (4)
    ) dut (
        .clk         (clk),
        .rst_ni      (rst_ni),
        .sig_i       (sig_i),
        .rise_en_i   (rise_en_i),
        .fall_en_i   (fall_en_i),
        .evt_valid_o (evt_valid_o),
        .evt_ready_i (evt_ready_i),
        .evt_ch_o    (evt_ch_o),
        .evt_rise_o  (evt_rise_o),
        .pending_o   (pending_o),
        .ovf_o       (ovf_o),
        .ovf_clr_i   (ovf_clr_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push_evt(input int ch, input bit rise);
        exp_t e;
        e.ch   = 2'(ch);
        e.rise = rise;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc && !evt_valid_o; i++) tick(1);
        check(tag, 32'(evt_valid_o), 32'd1);
    endtask

    task automatic drain(input string tag, input int max_cyc);
        int i;
        i = 0;
        while ((sb.size() != 0 || evt_valid_o) && i < max_cyc) begin
            tick(1);
            i++;
        end
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        tick(2);
        rst_ni = 1'b1;
    endtask

    // Handshake monitor: each accepted event must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_ni && evt_valid_o && evt_ready_i) begin
            if (sb.size() == 0) begin
                check("evt_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("evt_ch", 32'(evt_ch_o), 32'(e.ch));
                check("evt_rise", 32'(evt_rise_o), 32'(e.rise));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni      = 1'b0;
        sig_i       = 4'b0000;
        rise_en_i   = 4'b1111;
        fall_en_i   = 4'b1111;
        evt_ready_i = 1'b1;
        ovf_clr_i   = 4'b0000;

        // Reset state, held quiet after release.
        tick(3);
        check("rst_valid", 32'(evt_valid_o), 32'd0);
        rst_ni = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("idle_valid", 32'(evt_valid_o), 32'd0);
            check("idle_pending", 32'(pending_o), 32'd0);
            check("idle_ovf", 32'(ovf_o), 32'd0);
        end

        // Latency: s1 captures at edge k, pending at k+5, valid after k+6.
        sig_i[2] = 1'b1;
        push_evt(2, 1'b1);
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        check("lat_valid_early", 32'(evt_valid_o), 32'd0);
        check("lat_pending", 32'(pending_o), 32'h04);
        tick(1);
        check("lat_valid", 32'(evt_valid_o), 32'd1);
        check("lat_ch", 32'(evt_ch_o), 32'd2);
        check("lat_rise", 32'(evt_rise_o), 32'd1);
        tick(1);
        check("lat_single", 32'(evt_valid_o), 32'd0);
        sig_i[2] = 1'b0;
        push_evt(2, 1'b0);
        drain("lat_drain", 40);

        // Debounce: 3-cycle glitch ignored, 4-cycle pulse gives rise then fall.
        sig_i[0] = 1'b1;
        tick(3);
        sig_i[0] = 1'b0;
        tick(15);
        check("glitch_pending", 32'(pending_o), 32'd0);
        check("glitch_valid", 32'(evt_valid_o), 32'd0);
        sig_i[0] = 1'b1;
        push_evt(0, 1'b1);
        push_evt(0, 1'b0);
        tick(4);
        sig_i[0] = 1'b0;
        drain("deb_drain", 40);

        // Round-robin: ch0/1/3 rise together; a fresh ch0 rise waits behind ch3.
        do_reset();
        fall_en_i   = 4'b0000;
        evt_ready_i = 1'b0;
        sig_i       = 4'b1011;
        push_evt(0, 1'b1);
        push_evt(1, 1'b1);
        push_evt(3, 1'b1);
        push_evt(0, 1'b1);
        wait_valid("rr_first_timeout", 20);
        check("rr_first_ch", 32'(evt_ch_o), 32'd0);
        sig_i[0] = 1'b0;
        tick(8);
        sig_i[0] = 1'b1;
        tick(8);
        check("rr_pending", 32'(pending_o), 32'h0B);
        check("rr_ovf", 32'(ovf_o), 32'd0);
        check("rr_hold_ch", 32'(evt_ch_o), 32'd0);
        evt_ready_i = 1'b1;
        begin
            int rr_exp[3] = '{1, 3, 0};
            for (int i = 0; i < 3; i++) begin
                tick(1);
                check("rr_bubble", 32'(evt_valid_o), 32'd0);
                tick(1);
                check("rr_valid", 32'(evt_valid_o), 32'd1);
                check("rr_ch", 32'(evt_ch_o), 32'(rr_exp[i]));
            end
        end
        drain("rr_drain", 10);
        sig_i = 4'b0000;
        tick(12);
        fall_en_i = 4'b1111;
        check("rr_quiet", 32'(pending_o), 32'd0);

        // Backpressure and overflow on ch1.
        evt_ready_i = 1'b0;
        sig_i[1]    = 1'b1;
        push_evt(1, 1'b1);
        push_evt(1, 1'b1);
        push_evt(1, 1'b0);
        wait_valid("bp_timeout", 20);
        check("bp_ch", 32'(evt_ch_o), 32'd1);
        check("bp_rise", 32'(evt_rise_o), 32'd1);
        fall_en_i[1] = 1'b0;
        sig_i[1]     = 1'b0;
        tick(8);
        sig_i[1] = 1'b1;
        tick(8);
        check("bp_second_pending", 32'(pending_o), 32'h02);
        check("bp_second_ovf", 32'(ovf_o), 32'd0);
        fall_en_i[1] = 1'b1;
        sig_i[1]     = 1'b0;
        tick(8);
        check("bp_fall_pending", 32'(pending_o), 32'h22);
        check("bp_fall_ovf", 32'(ovf_o), 32'd0);
        check("bp_stable_ch", 32'(evt_ch_o), 32'd1);
        check("bp_stable_rise", 32'(evt_rise_o), 32'd1);
        check("bp_stable_valid", 32'(evt_valid_o), 32'd1);
        sig_i[1] = 1'b1;
        tick(8);
        check("bp_third_ovf", 32'(ovf_o), 32'h2);
        check("bp_third_pending", 32'(pending_o), 32'h22);
        tick(3);
        check("bp_ovf_sticky", 32'(ovf_o), 32'h2);
        ovf_clr_i = 4'b0010;
        tick(1);
        ovf_clr_i = 4'b0000;
        check("bp_ovf_clr", 32'(ovf_o), 32'd0);
        evt_ready_i = 1'b1;
        drain("bp_drain", 20);
        sig_i[1] = 1'b0;
        push_evt(1, 1'b0);
        drain("bp_fall_drain", 40);

        // Disabled rise on ch2 is not latched.
        rise_en_i = 4'b1011;
        sig_i[2]  = 1'b1;
        tick(12);
        check("dis_pending", 32'(pending_o), 32'd0);
        check("dis_valid", 32'(evt_valid_o), 32'd0);
        rise_en_i = 4'b1111;

        // Reset during OFFER drops the event for good.
        evt_ready_i = 1'b0;
        sig_i[3]    = 1'b1;
        wait_valid("rmo_timeout", 20);
        check("rmo_ch", 32'(evt_ch_o), 32'd3);
        rst_ni = 1'b0;
        #1;
        check("rmo_valid_drop", 32'(evt_valid_o), 32'd0);
        sig_i = 4'b0000;
        tick(2);
        rst_ni      = 1'b1;
        evt_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("rmo_no_replay", 32'(evt_valid_o), 32'd0);
        end
        check("rmo_pending", 32'(pending_o), 32'd0);
        check("rmo_ovf", 32'(ovf_o), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/edge_event_ctrl.md
Name: edge_event_ctrl

Overview:
- Multi-channel input event controller for slow external signals (buttons, switches, GPIO).
- Per channel: synchronises, debounces and edge-detects the input, then latches rising and falling edges as pending events.
- A round-robin arbiter serialises pending events onto a single valid/ready event port consumed by the peripheral/interrupt logic.

Parameters:
- NumCh, 4, number of input channels (>=2).
- DebounceCycles, 4, consecutive cycles an input must differ from the stable value before the stable value updates (>=1).
- ChW, $clog2(NumCh), derived; width of channel index.

Ports:
- clk  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- sig_i  in  NumCh  raw asynchronous inputs.
- rise_en_i  in  NumCh  per-channel rising-edge event enable.
- fall_en_i  in  NumCh  per-channel falling-edge event enable.
- evt_valid_o  out  1  event available.
- evt_ready_i  in  1  consumer accepts event.
- evt_ch_o  out  ChW  channel of offered event.
- evt_rise_o  out  1  1 = rising, 0 = falling.
- pending_o  out  2*NumCh  {fall pending, rise pending} per channel.
- ovf_o  out  NumCh  sticky overflow per channel.
- ovf_clr_i  in  NumCh  write-1-clear for ovf_o.

Behaviour:
- Reset (async, rst_ni=0):
  - All sync flops, stable values, counters, pending bits and ovf_o go to 0.
  - evt_valid_o=0, evt_ch_o=0, evt_rise_o=0; FSM goes to IDLE; RR pointer goes to 0.
  - Reset mid-offer drops the offered event.
- Synchroniser: 2 flops per channel (s1, s2).
- Debounce, per channel, with stable reg st and counter cnt of width $clog2(DebounceCycles+1):
  - s2==st: cnt<=0.
  - s2!=st and cnt<DebounceCycles-1: cnt<=cnt+1.
  - s2!=st and cnt==DebounceCycles-1: st<=s2, cnt<=0.
  - A glitch shorter than DebounceCycles cycles produces no event.
- Edge: rise = update with s2=1; fall = update with s2=0. An input already high at reset release yields a rise after debounce.
- Pending:
  - An edge with its enable set sets the matching pending bit at the same edge st updates.
  - Disabled edges are dropped; they are not latched.
- Overflow: an edge arriving while its pending bit is already 1 sets ovf_o[ch]. The pending bit stays 1 (events merge).
- Set/clear priority:
  - A pending set and a clear (arbiter grab) on the same cycle, same bit: the set wins and the bit stays 1.
  - An ovf set and ovf_clr_i on the same cycle: the set wins.
- FSM IDLE:
  - If any pending bit is set, select the first channel with a pending bit, searching from RR pointer upward with wrap-around.
  - Within the selected channel, rise has priority over fall.
  - Register evt_ch_o/evt_rise_o, clear that pending bit, set RR pointer to ch+1 (wrapping), go to OFFER.
- FSM OFFER:
  - evt_valid_o=1; evt_ch_o and evt_rise_o held stable until the handshake.
  - On evt_valid_o & evt_ready_i, go to IDLE (evt_valid_o=0 next cycle).
  - This gives one bubble between events: maximum throughput is 1 event / 2 cycles.
- Latency (idle controller, ready held 1): with sig_i change first captured by s1 at edge k:
  - st updates and pending sets at edge k+1+DebounceCycles.
  - evt_valid_o is high after edge k+2+DebounceCycles.
- Enable changes apply to edges detected after the change; pending bits are unaffected.

Decomposition:
- Package edge_event_pkg holds the FSM state enum (IDLE, OFFER) and an event struct {ch, rise}.
- Sub-module edge_event_chan holds the per-channel logic: synchroniser, debounce counter, stable reg, rise/fall pulse outputs. It is instantiated NumCh times via generate.
- Arbiter, pending/overflow regs and FSM live in the top module.

Test Plan:
- Reset: hold rst_ni=0, sig_i=4'b0000, enables all 1, release -> evt_valid_o=0, pending_o=0, ovf_o=0 indefinitely.
- Latency: ch2 sig_i 0->1, ready=1 -> evt_valid_o high exactly 6 edges after s1 capture; evt_ch_o=2, evt_rise_o=1; single handshake.
- Debounce: ch0 pulse high 3 cycles -> no event.
  - Pulse high 4 cycles -> rise event.
  - Fall event once the input has been low for 4 cycles.
- Round-robin: rises on ch0,1,3 in the same cycle, ready=1 -> events ch0, ch1, ch3 in order, one every 2 cycles.
  - A new ch0 rise arriving before ch3 has been taken is served after ch3.
- Backpressure/overflow: ready=0, ch1 rise offered; second ch1 rise then a fall while stalled -> evt_ch_o/evt_rise_o stable.
  - ovf_o[1]=0, since the second rise sets the pending bit cleared at grab.
  - A third rise while rise is pending -> ovf_o[1]=1.
  - ovf_clr_i[1] pulse -> 0.
- Reset mid-offer and disabled edges: rise_en_i[2]=0, ch2 rises -> no pending.
  - Assert rst_ni low during OFFER -> evt_valid_o drops immediately and no event is replayed after release.
